// File: rtl/sb_ctrl.sv
// -----------------------------------------------------------------------------
// sb_ctrl : single-port system bus controller shared by data access and fetch.
//
// Arbitrates execute-stage loads/stores and instruction fetches onto one bus
// with at most one transaction in flight. Data requests win over fetches in
// IDLE, but an in-flight fetch is never preempted. Misaligned data requests
// are rejected in IDLE with an error pulse and no bus cycle. A wait-state
// counter aborts a transaction that never receives bus_rvalid_i.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   mem_re_i/we_i   : data read / write request (both high = write)
//   mem_addr_i      : data byte address
//   mem_wdata_i     : store data (low bits valid for byte/halfword)
//   byte_sel_i      : 00 byte, 01 halfword, 10 word, 11 no request
//   load_sign_i     : sign-extend narrow loads
//   rd_waddr_i      : load destination register
//   if_req_i/addr_i : fetch request and word-aligned fetch address
//   bus_*_i         : grant, response valid, read data
//   bus_*_o         : request, word address, write enable, data, byte enables
//   hold_o          : stall pc/execute while a data access is pending
//   if_ack_o/data_o : fetch completion pulse and instruction
//   rd_*_o          : load writeback pulse, register, data
//   err_o           : misalignment or timeout pulse
// -----------------------------------------------------------------------------
module sb_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  byte_sel_i,
  input  logic        load_sign_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  output logic        hold_o,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_waddr_o,
  output logic [31:0] rd_wdata_o,
  output logic        err_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WADR_W = 30;

  localparam logic [1:0] BS_BYTE = 2'b00;
  localparam logic [1:0] BS_HALF = 2'b01;
  localparam logic [1:0] BS_NONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_D_REQ,
    S_D_WAIT,
    S_I_REQ,
    S_I_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WADR_W-1:0]  if_addr_q, if_addr_d;

  logic               d_valid;
  logic               misal;
  logic               timeout_hit;
  logic [3:0]         st_be;
  logic [31:0]        st_wdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;

  // Fetch addresses are word aligned; the low bits carry no information.
  logic               unused_if_lsb;
  assign unused_if_lsb = ^if_addr_i[1:0];

  // State, wait counter and captured fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      if_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if_addr_q <= if_addr_d;
    end
  end

  // Data request decode, store lane steering and load lane extraction.
  always_comb begin
    d_valid  = (mem_re_i | mem_we_i) && (byte_sel_i != BS_NONE);

    case (byte_sel_i)
      BS_HALF: misal = mem_addr_i[0];
      2'b10:   misal = (mem_addr_i[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase

    st_be    = 4'b1111;
    st_wdata = mem_wdata_i;
    case (byte_sel_i)
      BS_BYTE: begin
        st_be    = 4'b0001 << mem_addr_i[1:0];
        st_wdata = {4{mem_wdata_i[7:0]}};
      end
      BS_HALF: begin
        st_be    = 4'b0011 << {mem_addr_i[1], 1'b0};
        st_wdata = {2{mem_wdata_i[15:0]}};
      end
      default: ;
    endcase

    ld_byte = 8'(bus_rdata_i >> {mem_addr_i[1:0], 3'b000});
    ld_half = 16'(bus_rdata_i >> {mem_addr_i[1], 4'b0000});
    case (byte_sel_i)
      BS_BYTE: ld_data = {{24{load_sign_i & ld_byte[7]}}, ld_byte};
      BS_HALF: ld_data = {{16{load_sign_i & ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata_i;
    endcase

    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_addr_d   = if_addr_q;
    bus_req_o   = 1'b0;
    bus_addr_o  = '0;
    bus_we_o    = 1'b0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    if_ack_o    = 1'b0;
    if_data_o   = '0;
    rd_we_o     = 1'b0;
    rd_waddr_o  = '0;
    rd_wdata_o  = '0;
    err_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_valid && !misal) begin
          state_d = S_D_REQ;
        end else if (if_req_i) begin
          state_d   = S_I_REQ;
          if_addr_d = if_addr_i[31:2];
        end
        if (d_valid && misal) begin
          err_o = 1'b1;
        end
      end

      S_D_REQ: begin
        bus_req_o   = 1'b1;
        bus_addr_o  = {mem_addr_i[31:2], 2'b00};
        bus_we_o    = mem_we_i;
        bus_be_o    = mem_we_i ? st_be : 4'b1111;
        bus_wdata_o = mem_we_i ? st_wdata : '0;
        if (bus_gnt_i) begin
          state_d = S_D_WAIT;
          cnt_d   = '0;
        end
      end

      S_D_WAIT: begin
        if (bus_rvalid_i) begin
          state_d = S_IDLE;
          if (!mem_we_i) begin
            rd_we_o    = 1'b1;
            rd_waddr_o = rd_waddr_i;
            rd_wdata_o = ld_data;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_o   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_I_REQ: begin
        bus_req_o  = 1'b1;
        bus_addr_o = {if_addr_q, 2'b00};
        bus_be_o   = 4'b1111;
        if (bus_gnt_i) begin
          state_d = S_I_WAIT;
          cnt_d   = '0;
        end
      end

      S_I_WAIT: begin
        if (bus_rvalid_i) begin
          state_d   = S_IDLE;
          if_ack_o  = 1'b1;
          if_data_o = bus_rdata_i;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_o   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Stall while a data access is outstanding; released by its response or
    // by an immediate misalignment rejection.
    hold_o = d_valid
             && !((state_q == S_D_WAIT) && bus_rvalid_i)
             && !((state_q == S_IDLE) && misal);

    // Reset silences everything, including a response landing this cycle.
    if (rst) begin
      bus_req_o   = 1'b0;
      bus_addr_o  = '0;
      bus_we_o    = 1'b0;
      bus_wdata_o = '0;
      bus_be_o    = '0;
      if_ack_o    = 1'b0;
      if_data_o   = '0;
      rd_we_o     = 1'b0;
      rd_waddr_o  = '0;
      rd_wdata_o  = '0;
      err_o       = 1'b0;
      hold_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_sb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sb_ctrl : self-checking bench for sb_ctrl. Inputs change 1 time unit
// after the rising edge, outputs are checked on the falling edge. Expected
// bus lanes and load results come from byte-level reference functions.
// -----------------------------------------------------------------------------
module tb_sb_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        mem_re_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [1:0]  byte_sel_i;
  logic        load_sign_i;
  logic [4:0]  rd_waddr_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        hold_o, if_ack_o;
  logic [31:0] if_data_o;
  logic        rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  sb_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .byte_sel_i(byte_sel_i), .load_sign_i(load_sign_i),
    .rd_waddr_i(rd_waddr_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .hold_o(hold_o), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation bundles: every output, and the bus request fields.
  logic [142:0] all_outs;
  logic [69:0]  bus_v;
  assign all_outs = {bus_req_o, bus_addr_o, bus_we_o, bus_wdata_o, bus_be_o,
                     hold_o, if_ack_o, if_data_o, rd_we_o, rd_waddr_o,
                     rd_wdata_o, err_o};
  assign bus_v    = {bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o};

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [1:0] bs);
    return (bs == 2'b00) ? 1 : (bs == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] off, input logic [1:0] bs);
    logic [3:0] be;
    int sz;
    sz = acc_size(bs);
    for (int b = 0; b < 4; b++) be[b] = (b >= int'(off)) && (b < int'(off) + sz);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] bs);
    logic [31:0] v;
    int sz;
    sz = acc_size(bs);
    for (int b = 0; b < 4; b++) v[8*b +: 8] = wd[8*(b % sz) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdat, input logic [1:0] off,
                                           input logic [1:0] bs, input logic sg);
    logic [31:0] v;
    int sz;
    sz = acc_size(bs);
    v  = '0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = rdat[8*(int'(off) + b) +: 8];
    if (sg) for (int i = 8*sz; i < 32; i++) v[i] = v[8*sz-1];
    return v;
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic set_data(input logic re, input logic we, input logic [1:0] bs,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic sg, input logic [4:0] rd);
    mem_re_i = re; mem_we_i = we; byte_sel_i = bs; mem_addr_i = a;
    mem_wdata_i = wd; load_sign_i = sg; rd_waddr_i = rd;
  endtask

  task automatic clr_data();
    set_data(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic clr_bus();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_data(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 5'd3);
    if_req_i = 1'b1; if_addr_i = 32'h40;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_during got=%h exp=0", all_outs);
    end
    tick();
    rst = 1'b0; clr_data(); clr_bus(); if_req_i = 1'b0;
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL reset_idle got=%h exp=0", all_outs);
    end
    tick();
  endtask

  task automatic test_lb_sign();
    set_data(1'b1, 1'b0, 2'b00, 32'h1003, 32'h0, 1'b1, 5'd7);
    probe();
    total++;
    if ({hold_o, bus_req_o} !== 2'b10) begin
      bad++; $display("FAIL lb_idle got=%b exp=10", {hold_o, bus_req_o});
    end
    tick();
    bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h1000, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL lb_req got=%h exp=%h", bus_v, {1'b1, 32'h1000, 1'b0, 4'hF, 32'h0});
    end
    tick();
    bus_gnt_i = 1'b0;
    probe();
    total++;
    if ({rd_we_o, hold_o} !== 2'b01) begin
      bad++; $display("FAIL lb_wait got=%b exp=01", {rd_we_o, hold_o});
    end
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h80FF_FFFF;
    probe();
    total++;
    if ({rd_we_o, rd_waddr_o, rd_wdata_o, hold_o} !== {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0}) begin
      bad++; $display("FAIL lb_resp got=%b,%0d,%h,%b exp=1,7,ffffff80,0",
                      rd_we_o, rd_waddr_o, rd_wdata_o, hold_o);
    end
    tick();
    clr_data(); clr_bus();
    probe();
    total++;
    if ({rd_we_o, hold_o, bus_req_o} !== 3'b000) begin
      bad++; $display("FAIL lb_after got=%b exp=000", {rd_we_o, hold_o, bus_req_o});
    end
    tick();
  endtask

  task automatic test_store_sh();
    set_data(1'b0, 1'b1, 2'b01, 32'h2002, 32'h0000_BEEF, 1'b0, 5'd0);
    tick();
    bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h2000, 1'b1, 4'b1100, 32'hBEEF_BEEF}) begin
      bad++; $display("FAIL sh_req got=%h exp=%h", bus_v, {1'b1, 32'h2000, 1'b1, 4'b1100, 32'hBEEF_BEEF});
    end
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    probe();
    total++;
    if ({rd_we_o, hold_o, err_o} !== 3'b000) begin
      bad++; $display("FAIL sh_ack got=%b exp=000", {rd_we_o, hold_o, err_o});
    end
    tick();
    clr_data(); clr_bus();
  endtask

  task automatic test_priority();
    set_data(1'b1, 1'b0, 2'b10, 32'h4000, 32'h0, 1'b0, 5'd3);
    if_req_i = 1'b1; if_addr_i = 32'h8000_0100;
    tick();
    bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h4000, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL prio_data_first got=%h", bus_v);
    end
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    probe();
    total++;
    if ({rd_we_o, rd_wdata_o, hold_o, if_ack_o} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
      bad++; $display("FAIL prio_lw got=%b,%h,%b,%b", rd_we_o, rd_wdata_o, hold_o, if_ack_o);
    end
    tick();
    clr_data(); clr_bus();
    tick();
    bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h8000_0100, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL prio_fetch_req got=%h", bus_v);
    end
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    probe();
    total++;
    if ({if_ack_o, if_data_o, rd_we_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      bad++; $display("FAIL prio_fetch_ack got=%b,%h,%b exp=1,deadbeef,0", if_ack_o, if_data_o, rd_we_o);
    end
    tick();
    if_req_i = 1'b0; clr_bus();
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL prio_idle got=%h exp=0", all_outs);
    end
    tick();
  endtask

  task automatic test_no_preempt();
    if_req_i = 1'b1; if_addr_i = 32'h200;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    set_data(1'b1, 1'b0, 2'b10, 32'h500, 32'h0, 1'b0, 5'd9);
    probe();
    total++;
    if ({hold_o, bus_req_o} !== 2'b10) begin
      bad++; $display("FAIL nopre_wait got=%b exp=10", {hold_o, bus_req_o});
    end
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
    probe();
    total++;
    if ({if_ack_o, if_data_o, hold_o} !== {1'b1, 32'hCAFE_0001, 1'b1}) begin
      bad++; $display("FAIL nopre_ack got=%b,%h,%b", if_ack_o, if_data_o, hold_o);
    end
    tick();
    if_req_i = 1'b0; clr_bus();
    tick();
    bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h500, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL nopre_dreq got=%h", bus_v);
    end
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    probe();
    total++;
    if ({rd_we_o, rd_waddr_o, rd_wdata_o, hold_o} !== {1'b1, 5'd9, 32'h0BAD_F00D, 1'b0}) begin
      bad++; $display("FAIL nopre_lw got=%b,%0d,%h,%b", rd_we_o, rd_waddr_o, rd_wdata_o, hold_o);
    end
    tick();
    clr_data(); clr_bus();
  endtask

  task automatic test_misaligned();
    logic [1:0]  bs_t [4];
    logic [31:0] ad_t [4];
    logic        we_t [4];
    bs_t = '{2'b10, 2'b01, 2'b10, 2'b01};
    ad_t = '{32'h3001, 32'h3003, 32'h3002, 32'h3005};
    we_t = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      set_data(~we_t[k], we_t[k], bs_t[k], ad_t[k], 32'h55AA_55AA, 1'b0, 5'd1);
      bus_gnt_i = 1'b1;
      probe();
      total++;
      if ({err_o, hold_o, bus_req_o} !== 3'b100) begin
        bad++; $display("FAIL misal_%0d got=%b exp=100", k, {err_o, hold_o, bus_req_o});
      end
      tick();
      clr_data();
      probe();
      total++;
      if ({err_o, hold_o, bus_req_o} !== 3'b000) begin
        bad++; $display("FAIL misal_after_%0d got=%b exp=000", k, {err_o, hold_o, bus_req_o});
      end
      tick();
      clr_bus();
    end
  endtask

  task automatic test_timeout();
    set_data(1'b1, 1'b0, 2'b10, 32'h6000, 32'h0, 1'b0, 5'd4);
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    for (int w = 1; w <= int'(TIMEOUT); w++) begin
      probe();
      total++;
      if (w < int'(TIMEOUT)) begin
        if ({err_o, rd_we_o, hold_o, bus_req_o} !== 4'b0010) begin
          bad++; $display("FAIL tmo_wait_%0d got=%b exp=0010", w, {err_o, rd_we_o, hold_o, bus_req_o});
        end
      end else begin
        if ({err_o, rd_we_o, hold_o, bus_req_o} !== 4'b1010) begin
          bad++; $display("FAIL tmo_fire got=%b exp=1010", {err_o, rd_we_o, hold_o, bus_req_o});
        end
      end
      tick();
    end
    // Late response must be ignored; a fetch proves the FSM is back in IDLE.
    clr_data(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    if_req_i = 1'b1; if_addr_i = 32'h700;
    probe();
    total++;
    if ({rd_we_o, err_o, bus_req_o, hold_o, if_ack_o} !== 5'b00000) begin
      bad++; $display("FAIL tmo_late got=%b exp=00000", {rd_we_o, err_o, bus_req_o, hold_o, if_ack_o});
    end
    tick();
    bus_rvalid_i = 1'b0; bus_gnt_i = 1'b1;
    probe();
    total++;
    if (bus_v !== {1'b1, 32'h700, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL tmo_idle_fetch got=%h", bus_v);
    end
    tick();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0013;
    tick();
    if_req_i = 1'b0; clr_bus();
  endtask

  task automatic test_reset_inflight();
    set_data(1'b1, 1'b0, 2'b10, 32'h7000, 32'h0, 1'b0, 5'd12);
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    tick();
    rst = 1'b1;
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL rstwait_during got=%h exp=0", all_outs);
    end
    tick();
    rst = 1'b0; clr_data(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'hABCD_EF01;
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL rstwait_late got=%h exp=0", all_outs);
    end
    tick();
    clr_bus();
    probe();
    total++;
    if (all_outs !== '0) begin
      bad++; $display("FAIL rstwait_idle got=%h exp=0", all_outs);
    end
    tick();
  endtask

  task automatic test_random_data();
    logic [1:0]  bs;
    logic [31:0] a, wd, rdat;
    logic        re, we, sg, is_wr;
    logic [4:0]  rd;
    int          gd, rdl;
    for (int it = 0; it < 60; it++) begin
      bs = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (bs == 2'b01) a[0] = 1'b0;
      if (bs == 2'b10) a[1:0] = 2'b00;
      wd = $urandom; sg = 1'($urandom); rd = 5'($urandom);
      case ($urandom_range(0, 2))
        0:       begin re = 1'b1; we = 1'b0; end
        1:       begin re = 1'b0; we = 1'b1; end
        default: begin re = 1'b1; we = 1'b1; end
      endcase
      is_wr = we;
      gd  = $urandom_range(0, 3);
      rdl = $urandom_range(0, 5);
      set_data(re, we, bs, a, wd, sg, rd);
      probe();
      total++;
      if ({hold_o, bus_req_o, err_o} !== 3'b100) begin
        bad++; $display("FAIL rnd_idle_%0d got=%b exp=100", it, {hold_o, bus_req_o, err_o});
      end
      tick();
      for (int g = 0; g <= gd; g++) begin
        bus_gnt_i = (g == gd); bus_rvalid_i = 1'($urandom);
        probe();
        total++;
        if (bus_v !== {1'b1, a[31:2], 2'b00, is_wr,
                       is_wr ? ref_be(a[1:0], bs) : 4'hF,
                       is_wr ? ref_wdata(wd, bs) : 32'h0}) begin
          bad++; $display("FAIL rnd_req_%0d got=%h bs=%b a=%h wd=%h wr=%b", it, bus_v, bs, a, wd, is_wr);
        end
        tick();
      end
      for (int w = 0; w <= rdl; w++) begin
        bus_rvalid_i = (w == rdl); bus_gnt_i = 1'($urandom); rdat = $urandom;
        bus_rdata_i = rdat;
        probe();
        total++;
        if (w < rdl) begin
          if ({rd_we_o, err_o, hold_o, bus_req_o} !== 4'b0010) begin
            bad++; $display("FAIL rnd_wait_%0d got=%b exp=0010", it, {rd_we_o, err_o, hold_o, bus_req_o});
          end
        end else if (is_wr) begin
          if ({rd_we_o, hold_o, err_o} !== 3'b000) begin
            bad++; $display("FAIL rnd_st_ack_%0d got=%b exp=000", it, {rd_we_o, hold_o, err_o});
          end
        end else begin
          if ({rd_we_o, rd_waddr_o, rd_wdata_o, hold_o, err_o} !==
              {1'b1, rd, ref_load(rdat, a[1:0], bs, sg), 1'b0, 1'b0}) begin
            bad++; $display("FAIL rnd_ld_%0d got=%b,%0d,%h exp=1,%0d,%h", it, rd_we_o, rd_waddr_o,
                            rd_wdata_o, rd, ref_load(rdat, a[1:0], bs, sg));
          end
        end
        tick();
      end
      clr_data(); clr_bus();
      probe();
      total++;
      if ({rd_we_o, hold_o, bus_req_o, err_o} !== 4'b0000) begin
        bad++; $display("FAIL rnd_after_%0d got=%b exp=0000", it, {rd_we_o, hold_o, bus_req_o, err_o});
      end
      tick();
    end
  endtask

  task automatic test_random_fetch();
    logic [31:0] fa, ins;
    int          gd, rdl;
    for (int it = 0; it < 20; it++) begin
      fa = $urandom; fa[1:0] = 2'b00;
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 4);
      if_req_i = 1'b1; if_addr_i = fa;
      tick();
      for (int g = 0; g <= gd; g++) begin
        bus_gnt_i = (g == gd);
        probe();
        total++;
        if (bus_v !== {1'b1, fa, 1'b0, 4'hF, 32'h0}) begin
          bad++; $display("FAIL rndf_req_%0d got=%h exp addr=%h", it, bus_v, fa);
        end
        tick();
      end
      bus_gnt_i = 1'b0;
      for (int w = 0; w <= rdl; w++) begin
        ins = $urandom;
        bus_rvalid_i = (w == rdl); bus_rdata_i = ins;
        probe();
        total++;
        if ({if_ack_o, if_data_o} !== ((w == rdl) ? {1'b1, ins} : 33'h0)) begin
          bad++; $display("FAIL rndf_ack_%0d got=%b,%h exp=%b,%h", it, if_ack_o, if_data_o,
                          (w == rdl), ins);
        end
        tick();
      end
      if_req_i = 1'b0; clr_bus();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_data(); clr_bus();
    if_req_i = 1'b0; if_addr_i = 32'h0;
    test_reset();
    test_lb_sign();
    test_store_sh();
    test_priority();
    test_no_preempt();
    test_misaligned();
    test_timeout();
    test_reset_inflight();
    test_random_data();
    test_random_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
